// File: rtl/crp16_mem_arbiter_if.sv
// Port B bus of the CRP16 data RAM as seen by the arbiter: two requesters,
// shared load data, and the RAM pins themselves.
interface crp16_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;

  logic        dbg_req;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;

  logic [15:0] rdata;

  logic [15:0] address_b;
  logic [15:0] data_b;
  logic        wren_b;
  logic [15:0] q_b;

  // master: the requesters plus the RAM model; slave: the arbiter
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output q_b,
    input  cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, rdata,
    input  address_b, data_b, wren_b
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  q_b,
    output cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, rdata,
    output address_b, data_b, wren_b
  );
endinterface

// File: rtl/crp16_mem_arbiter.sv
// Fixed-priority (cpu first) arbiter for RAM port B with a starvation
// override that guarantees the debug master a slot every STARVE_LIMIT+1 cycles.
module crp16_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  crp16_mem_arbiter_if.slave bus
);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]  starve;
  logic        access_valid;
  logic        owner;
  logic        override;
  logic        cpu_gnt;
  logic        dbg_gnt;
  logic        wren_q;
  logic [15:0] address_q;
  logic [15:0] data_q;
  logic [15:0] rdata_q;
  logic        cpu_rvalid_q;
  logic        dbg_rvalid_q;

  always_comb begin
    override = (starve == LIMIT) && bus.dbg_req;
    cpu_gnt  = !reset && bus.cpu_req && !override;
    dbg_gnt  = !reset && bus.dbg_req && (override || !bus.cpu_req);
  end

  // wren_q doubles as the latched we: it is only ever high during an access cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve       <= '0;
      access_valid <= 1'b0;
      owner        <= 1'b0;
      wren_q       <= 1'b0;
      address_q    <= '0;
      data_q       <= '0;
      rdata_q      <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      access_valid <= cpu_gnt || dbg_gnt;
      if (dbg_gnt) begin
        owner     <= 1'b1;
        wren_q    <= bus.dbg_we;
        address_q <= bus.dbg_addr;
        data_q    <= bus.dbg_wdata;
      end else if (cpu_gnt) begin
        owner     <= 1'b0;
        wren_q    <= bus.cpu_we;
        address_q <= bus.cpu_addr;
        data_q    <= bus.cpu_wdata;
      end else begin
        wren_q <= 1'b0;
      end

      if (access_valid && !wren_q) begin
        rdata_q      <= bus.q_b;
        cpu_rvalid_q <= !owner;
        dbg_rvalid_q <= owner;
      end else begin
        cpu_rvalid_q <= 1'b0;
        dbg_rvalid_q <= 1'b0;
      end

      if (dbg_gnt || !bus.dbg_req)
        starve <= '0;
      else if (starve != LIMIT)
        starve <= starve + 8'd1;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.rdata      = rdata_q;
  assign bus.address_b  = address_q;
  assign bus.data_b     = data_q;
  assign bus.wren_b     = wren_q;
endmodule
